// File: rtl/if_stage_pkg.sv
// Shared IF/ID definitions: instruction-type codes, MIPS opcodes, fetch state and buffer entry.
package if_stage_pkg;
  localparam logic [3:0] INST_TYPE_NONE   = 4'd0;
  localparam logic [3:0] INST_TYPE_RTYPE  = 4'd1;
  localparam logic [3:0] INST_TYPE_IMM    = 4'd2;
  localparam logic [3:0] INST_TYPE_LOAD   = 4'd3;
  localparam logic [3:0] INST_TYPE_STORE  = 4'd4;
  localparam logic [3:0] INST_TYPE_BRANCH = 4'd5;
  localparam logic [3:0] INST_TYPE_JUMP   = 4'd6;
  localparam logic [3:0] INST_TYPE_OTHER  = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {ST_RUN, ST_DRAIN} fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } if_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// IF-stage bus: instruction-memory handshake, redirect/stall from ID, and the IF/ID buffer outputs.
interface if_stage_if;
  logic        cu_wpcir;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [3:0]  if_ins_type;
  logic [3:0]  if_ins_number;

  modport master (
    input  cu_wpcir, br_taken, br_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_inst, if_pc4, if_valid, if_ins_type, if_ins_number
  );
  modport slave (
    output cu_wpcir, br_taken, br_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_inst, if_pc4, if_valid, if_ins_type, if_ins_number
  );
endinterface

// File: rtl/if_stage_inst_classify.sv
// Combinational instruction -> INST_TYPE_* decoder, shared with later pipeline stages.
module if_stage_inst_classify
  import if_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  ins_type
);
  logic [5:0] op;
  assign op = inst[31:26];

  always_comb begin
    ins_type = INST_TYPE_OTHER;
    if (inst == 32'h0) ins_type = INST_TYPE_NONE;
    else begin
      case (op)
        OP_RTYPE:       ins_type = INST_TYPE_RTYPE;
        OP_J, OP_JAL:   ins_type = INST_TYPE_JUMP;
        OP_BEQ, OP_BNE: ins_type = INST_TYPE_BRANCH;
        OP_LW:          ins_type = INST_TYPE_LOAD;
        OP_SW:          ins_type = INST_TYPE_STORE;
        default:        if (op[5:3] == 3'b001) ins_type = INST_TYPE_IMM;
      endcase
    end
  end
endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ack fetch, single-entry IF/ID buffer, redirect with drain.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  if_stage_if.master bus
);
  fetch_state_e state;
  logic [31:0]  pc, tgt_q;
  logic         buf_valid;
  logic [3:0]   seq;
  if_entry_t    q;
  logic         consume, imem_req, fire;
  logic [3:0]   rd_type;

  if_stage_inst_classify u_classify (.inst(bus.imem_rdata), .ins_type(rd_type));

  // The buffer stays empty until the ack, so req cannot drop mid-fetch.
  assign consume  = buf_valid & ~bus.cu_wpcir;
  assign imem_req = ~rst & ((state == ST_DRAIN) | ~buf_valid | consume);
  assign fire     = imem_req & bus.imem_ack;

  assign bus.imem_req      = imem_req;
  assign bus.imem_addr     = pc;
  assign bus.if_inst       = q.inst;
  assign bus.if_pc4        = q.pc4;
  assign bus.if_valid      = buf_valid;
  assign bus.if_ins_type   = q.ins_type;
  assign bus.if_ins_number = q.ins_number;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      tgt_q     <= '0;
      buf_valid <= 1'b0;
      seq       <= '0;
      q         <= '{inst: NOP_INST, pc4: 32'h0, ins_type: INST_TYPE_NONE, ins_number: 4'h0};
    end else if (bus.br_taken) begin
      buf_valid  <= 1'b0;
      q.inst     <= NOP_INST;
      q.ins_type <= INST_TYPE_NONE;
      // An unacked fetch cannot be withdrawn; park the target until it completes.
      if (imem_req & ~bus.imem_ack) begin
        tgt_q <= bus.br_target;
        state <= ST_DRAIN;
      end else begin
        pc    <= bus.br_target;
        state <= ST_RUN;
      end
    end else if (state == ST_DRAIN) begin
      if (bus.imem_ack) begin
        pc    <= tgt_q;
        state <= ST_RUN;
      end
    end else if (fire) begin
      q         <= '{inst: bus.imem_rdata, pc4: pc + 32'd4, ins_type: rd_type, ins_number: seq};
      seq       <= seq + 4'd1;
      pc        <= pc + 32'd4;
      buf_valid <= 1'b1;
    end else if (consume) begin
      buf_valid  <= 1'b0;
      q.inst     <= NOP_INST;
      q.ins_type <= INST_TYPE_NONE;
    end
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer side of the IF/ID interface that the ID stage consumes.
- Owns the PC and issues word fetches over a req/ack instruction-memory handshake.
- Holds one fetched instruction in a single-entry output buffer, which ID consumes. Honours the cu_wpcir stall from ID.
- Redirects on taken branch/jump with flush. Tags each instruction with type and sequence number for the debug display.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INST, 32'h0000_0000, instruction presented when buffer empty

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cu_wpcir  in  1  ID stall; 1 = ID does not consume this cycle
br_taken  in  1  single-cycle redirect pulse from ID
br_target  in  32  redirect PC, valid with br_taken
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid; meaningful only while imem_req=1
imem_rdata  in  32  fetched instruction
if_inst  out  32  buffered instruction, or NOP_INST when empty
if_pc4  out  32  PC+4 of buffered instruction
if_valid  out  1  buffer holds a live instruction
if_ins_type  out  4  INST_TYPE_* of if_inst
if_ins_number  out  4  sequence tag of if_inst

Behaviour:
- Reset (async): pc=RESET_PC; state=RUN; buf_valid=0; if_inst=NOP_INST; if_pc4=0; if_ins_type=NONE; if_ins_number=0; seq counter=0; imem_req forced 0 while rst high.
- consume = buf_valid & ~cu_wpcir. The buffer is freed at that edge.
- RUN:
  - imem_req = ~buf_valid | consume; imem_addr = pc.
  - Once imem_req rises it stays high with a stable address until imem_ack. This holds by construction: the buffer is empty until the ack.
  - On imem_req & imem_ack (no br_taken): the buffer loads imem_rdata, with pc4 = pc+4, type = decode, number = seq. Then seq <= seq+1 (wraps 15→0), pc <= pc+4, buf_valid = 1.
  - Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle.
- br_taken (any state, highest priority):
  - Buffer invalidated (if_valid=0, if_inst=NOP_INST, type=NONE). No delay slot.
  - If no fetch is outstanding, or imem_ack arrives the same cycle: ack data discarded; pc <= br_target; stay RUN.
  - If imem_req=1 and imem_ack=0: latch br_target into tgt_q; state <= DRAIN.
- DRAIN:
  - imem_req held 1 with the old address until imem_ack. Returned data discarded; seq not incremented.
  - On ack: pc <= tgt_q; state <= RUN.
  - A second br_taken in DRAIN overwrites tgt_q.
- Stall: cu_wpcir=1 with buf_valid=1 → buffer and all if_* outputs hold; no new request issued.
- Discarded or flushed instructions never consume a sequence number.
- Decode to INST_TYPE_* from opcode [31:26]:
  - inst == 0 → NONE
  - op 0 → RTYPE
  - 08–0F → IMM
  - 23 → LOAD
  - 2B → STORE
  - 04/05 → BRANCH
  - 02/03 → JUMP
  - else → OTHER
- pc arithmetic is 32-bit and wraps modulo 2^32. The low 2 bits are carried as-is.
- if_* outputs are registered. Only imem_req and imem_addr are combinational from state, pc and buf_valid.

Decomposition:
- Shared macro.vh holds INST_TYPE_NONE=0, RTYPE=1, IMM=2, LOAD=3, STORE=4, BRANCH=5, JUMP=6, OTHER=7, plus the opcode constants. The ID stage uses the same definitions.
- One natural sub-module: inst_classify, a combinational inst → 4-bit type decoder that is reusable in later stages. Everything else stays inline.

Test Plan:
- Reset release, zero-wait memory, rdata=pc-indexed pattern, cu_wpcir=0 → addrs 0,4,8,… one per cycle. if_pc4 = 4,8,C… if_ins_number = 0,1,2…, wraps 15→0 on the 17th instruction.
- cu_wpcir=1 for 3 cycles with buffer valid → if_inst/if_pc4/number frozen; imem_req=0. Release → next fetch at the held pc+4, no number skipped.
- 3-cycle memory latency → imem_req high with a stable imem_addr for 3 cycles; if_valid=1 the cycle after ack; if_inst=NOP_INST and type NONE while empty.
- br_taken, br_target=0x100, no fetch outstanding → buffer flushed next cycle; next imem_addr=0x100; seq continues without a gap.
- br_taken (target 0x200) mid 3-cycle fetch of 0x40 → req stays at 0x40 until ack; data dropped, if_valid stays 0. Next request at 0x200; its number = last delivered +1.
- Assert rst mid-DRAIN → immediate return to reset values; first request after release at RESET_PC; tgt_q ignored.
- Decode sweep: 0x00000000→NONE, 0x8C.. (lw)→LOAD, 0xAC.. (sw)→STORE, 0x10.. (beq)→BRANCH, 0x08.. (j)→JUMP, 0x20.. (addi)→IMM, 0x012A4020 (add)→RTYPE.
